// File: rtl/lsu_pkg.sv
// Shared types and fault rules for the load/store unit.
// Misaligned-access faulting is enabled by defining LSU_ALIGN_CHECK_EN.
package lsu_pkg;

    typedef enum logic [1:0] {
        SIZE_BYTE    = 2'b00,
        SIZE_HALF    = 2'b01,
        SIZE_WORD    = 2'b10,
        SIZE_ILLEGAL = 2'b11
    } lsu_size_e;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        ACCESS = 2'b01,
        RESP   = 2'b10
    } lsu_state_e;

    function automatic logic is_misaligned(lsu_size_e size, logic [1:0] offset);
        logic result;
        result = 1'b0;
        if (size == SIZE_HALF) begin
            result = offset[0];
        end else if (size == SIZE_WORD) begin
            result = (offset != 2'b00);
        end
        return result;
    endfunction

    // Misaligned requests either fault or reach here and get force-aligned.
    function automatic logic [1:0] align_offset(lsu_size_e size, logic [1:0] offset);
        logic [1:0] result;
        result = offset;
        if (size == SIZE_HALF) begin
            result = {offset[1], 1'b0};
        end else if (size == SIZE_WORD) begin
            result = 2'b00;
        end
        return result;
    endfunction

    function automatic logic request_fault(lsu_size_e size, logic [31:0] addr,
                                           logic [31:0] capacity);
        logic result;
        result = (size == SIZE_ILLEGAL) || (addr >= capacity);
`ifdef LSU_ALIGN_CHECK_EN
        result = result || is_misaligned(size, addr[1:0]);
`endif
        return result;
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational byte-lane steering: store replication/byte mask and
// load lane extraction with sign or zero extension.
module lsu_lane_align
    import lsu_pkg::*;
(
    input  lsu_size_e   size,
    input  logic [1:0]  offset,
    input  logic        is_unsigned,
    input  logic [31:0] store_data,
    input  logic [31:0] load_word,
    output logic [3:0]  byte_mask,
    output logic [31:0] store_word,
    output logic [31:0] load_data
);

    logic [31:0] shifted;

    assign shifted = load_word >> {offset, 3'b000};

    always_comb begin
        byte_mask  = 4'b0000;
        store_word = 32'h0;
        load_data  = 32'h0;
        case (size)
            SIZE_BYTE: begin
                byte_mask  = 4'b0001 << offset;
                store_word = {4{store_data[7:0]}};
                load_data  = is_unsigned ? {24'h0, shifted[7:0]}
                                         : {{24{shifted[7]}}, shifted[7:0]};
            end
            SIZE_HALF: begin
                byte_mask  = 4'b0011 << offset;
                store_word = {2{store_data[15:0]}};
                load_data  = is_unsigned ? {16'h0, shifted[15:0]}
                                         : {{16{shifted[15]}}, shifted[15:0]};
            end
            SIZE_WORD: begin
                byte_mask  = 4'b1111;
                store_word = store_data;
                load_data  = load_word;
            end
            default: begin
                byte_mask  = 4'b0000;
                store_word = 32'h0;
                load_data  = 32'h0;
            end
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: three-state request FSM driving one synchronous memory port.
// Define LSU_ALIGN_CHECK_EN to fault misaligned accesses instead of force-aligning.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int CAPACITY_BYTES = 128,
    parameter int BYTES_PER_WORD = 4,
    localparam int ADDR_BITS = $clog2(CAPACITY_BYTES)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_write,
    input  logic [1:0]           req_size,
    input  logic                 req_unsigned,
    input  logic [31:0]          req_addr,
    input  logic [31:0]          req_wr_data,
    output logic                 rsp_valid,
    output logic [31:0]          rsp_rd_data,
    output logic                 rsp_fault,
    output logic                 mem_reset,
    output logic [ADDR_BITS-1:0] mem_address,
    output logic                 mem_rd_en,
    output logic [31:0]          mem_wr_data,
    output logic [3:0]           mem_wr_en,
    input  logic [31:0]          mem_rd_data
);

    localparam int LANE_BITS = $clog2(BYTES_PER_WORD);

    lsu_state_e           state;
    lsu_state_e           state_next;
    logic                 r_write;
    lsu_size_e            r_size;
    logic                 r_unsigned;
    logic [ADDR_BITS-1:0] r_addr;
    logic [31:0]          r_wr_data;
    logic                 r_fault;

    lsu_size_e            in_size;
    logic                 in_fault;
    logic                 accept;
    logic [3:0]           lane_mask;
    logic [31:0]          lane_store;
    logic [31:0]          lane_load;

    assign in_size   = lsu_size_e'(req_size);
    assign in_fault  = request_fault(in_size, req_addr, 32'(CAPACITY_BYTES));
    assign accept    = (state == IDLE) && req_valid;
    assign mem_reset = reset;

    // The stored offset is already force-aligned, so lanes never straddle a word.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            r_write    <= 1'b0;
            r_size     <= SIZE_BYTE;
            r_unsigned <= 1'b0;
            r_addr     <= '0;
            r_wr_data  <= 32'h0;
            r_fault    <= 1'b0;
        end else begin
            state <= state_next;
            if (accept) begin
                r_write    <= req_write;
                r_size     <= in_size;
                r_unsigned <= req_unsigned;
                r_addr     <= {req_addr[ADDR_BITS-1:LANE_BITS],
                               align_offset(in_size, req_addr[1:0])};
                r_wr_data  <= req_wr_data;
                r_fault    <= in_fault;
            end
        end
    end

    always_comb begin
        state_next = state;
        req_ready  = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    state_next = in_fault ? RESP : ACCESS;
                end
            end
            ACCESS:  state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    lsu_lane_align u_lane_align (
        .size        (r_size),
        .offset      (r_addr[1:0]),
        .is_unsigned (r_unsigned),
        .store_data  (r_wr_data),
        .load_word   (mem_rd_data),
        .byte_mask   (lane_mask),
        .store_word  (lane_store),
        .load_data   (lane_load)
    );

    // Gating with reset keeps an interrupted store from reaching memory.
    always_comb begin
        mem_address = '0;
        mem_rd_en   = 1'b0;
        mem_wr_en   = 4'b0000;
        mem_wr_data = 32'h0;
        rsp_valid   = 1'b0;
        rsp_fault   = 1'b0;
        rsp_rd_data = 32'h0;
        if (!reset && state == ACCESS) begin
            mem_address = {r_addr[ADDR_BITS-1:LANE_BITS], {LANE_BITS{1'b0}}};
            mem_rd_en   = !r_write;
            if (r_write) begin
                mem_wr_en   = lane_mask;
                mem_wr_data = lane_store;
            end
        end
        if (!reset && state == RESP) begin
            rsp_valid = 1'b1;
            rsp_fault = r_fault;
            if (!r_write && !r_fault) begin
                rsp_rd_data = lane_load;
            end
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed vectors plus random traffic
// against a byte-array reference model. Honours LSU_ALIGN_CHECK_EN.
module tb_load_store_unit;

    localparam int CAP = 128;
`ifdef LSU_ALIGN_CHECK_EN
    localparam bit ALIGN_CHECK = 1'b1;
`else
    localparam bit ALIGN_CHECK = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wr_data;
    logic        rsp_valid;
    logic [31:0] rsp_rd_data;
    logic        rsp_fault;
    logic        mem_reset;
    logic [6:0]  mem_address;
    logic        mem_rd_en;
    logic [31:0] mem_wr_data;
    logic [3:0]  mem_wr_en;
    logic [31:0] mem_rd_data = 32'h0;

    logic [31:0] mem_word [0:CAP/4-1];
    logic [7:0]  ref_mem  [0:CAP-1];

    int assertion_count = 0;
    int fail_count = 0;

    logic [31:0] obs_data;
    logic        obs_fault;
    logic [3:0]  obs_mask;
    logic [31:0] obs_wdata;
    logic [31:0] obs_addr;

    always #5 clk = ~clk;

    load_store_unit #(.CAPACITY_BYTES(CAP), .BYTES_PER_WORD(4)) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_write    (req_write),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wr_data  (req_wr_data),
        .rsp_valid    (rsp_valid),
        .rsp_rd_data  (rsp_rd_data),
        .rsp_fault    (rsp_fault),
        .mem_reset    (mem_reset),
        .mem_address  (mem_address),
        .mem_rd_en    (mem_rd_en),
        .mem_wr_data  (mem_wr_data),
        .mem_wr_en    (mem_wr_en),
        .mem_rd_data  (mem_rd_data)
    );

    // Synchronous-read memory with byte write enables
    always @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (mem_wr_en[i]) mem_word[mem_address[6:2]][i*8 +: 8] <= mem_wr_data[i*8 +: 8];
        end
        if (mem_rd_en) mem_rd_data <= mem_word[mem_address[6:2]];
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        assertion_count++;
        if (observed !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s: observed 0x%08h, expected 0x%08h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic write, input logic [1:0] size,
                                 input logic uns, input logic [31:0] addr,
                                 input logic [31:0] data);
        int          n;
        int          eff;
        int          cycles;
        bit          got;
        bit          saw_rd;
        bit          saw_wr;
        logic        exp_fault;
        logic [3:0]  exp_mask;
        logic [31:0] exp_wdata;
        logic [31:0] exp_data;
        longint unsigned v;

        n = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
        exp_fault = (size == 2'd3) || (addr >= CAP) ||
                    (ALIGN_CHECK && (addr % n != 0));
        eff = 0;
        exp_mask = 4'b0000;
        exp_data = 32'h0;
        exp_wdata = (n == 1) ? {4{data[7:0]}} : (n == 2) ? {2{data[15:0]}} : data;
        if (!exp_fault) begin
            eff = int'(addr) - int'(addr) % n;
            for (int i = 0; i < n; i++) exp_mask[eff % 4 + i] = 1'b1;
            if (!write) begin
                v = 0;
                for (int i = 0; i < n; i++) v = v | (longint'(ref_mem[eff + i]) << (8 * i));
                if (!uns && ((v >> (8 * n - 1)) & 1) == 1) v = v | ~((64'd1 << (8 * n)) - 1);
                exp_data = v[31:0];
            end
        end

        @(negedge clk);
        req_valid = 1'b1; req_write = write; req_size = size;
        req_unsigned = uns; req_addr = addr; req_wr_data = data;
        checkOutput("req_ready", {31'h0, req_ready}, 32'd1);
        @(negedge clk);
        req_valid = 1'b0;

        cycles = 1; got = 0; saw_rd = 0; saw_wr = 0;
        obs_mask = 4'b0000; obs_wdata = 32'h0; obs_addr = 32'h0;
        obs_data = 32'h0; obs_fault = 1'b0;
        while (!got && cycles <= 4) begin
            if (mem_rd_en) begin saw_rd = 1; obs_addr = {25'h0, mem_address}; end
            if (mem_wr_en != 4'b0000) begin
                saw_wr = 1; obs_mask = mem_wr_en; obs_wdata = mem_wr_data;
                obs_addr = {25'h0, mem_address};
            end
            if (rsp_valid) begin
                got = 1; obs_fault = rsp_fault; obs_data = rsp_rd_data;
            end else begin
                @(negedge clk);
                cycles++;
            end
        end

        checkOutput("latency", cycles, exp_fault ? 32'd1 : 32'd2);
        checkOutput("rsp_fault", {31'h0, obs_fault}, {31'h0, exp_fault});
        checkOutput("rsp_rd_data", obs_data, exp_data);
        if (exp_fault) begin
            checkOutput("no_mem_access", {30'h0, saw_rd, saw_wr}, 32'h0);
        end else begin
            checkOutput("mem_rd_en", {31'h0, saw_rd}, {31'h0, !write});
            checkOutput("mem_address", obs_addr, 32'(eff - eff % 4));
            checkOutput("mem_wr_en", {28'h0, obs_mask}, write ? {28'h0, exp_mask} : 32'h0);
            if (write) begin
                checkOutput("mem_wr_data", obs_wdata, exp_wdata);
                for (int i = 0; i < n; i++) ref_mem[eff + i] = data[8*i +: 8];
            end
        end

        @(negedge clk);
        checkOutput("ready_after", {31'h0, req_ready}, 32'd1);
        checkOutput("rsp_single", {31'h0, rsp_valid}, 32'd0);
    endtask

    initial begin
        logic [31:0] ref_word;
        logic [31:0] r_addr;

        for (int i = 0; i < CAP; i++) begin
            ref_mem[i] = 8'($urandom);
            if (i % 4 == 3)
                mem_word[i / 4] = {ref_mem[i], ref_mem[i-1], ref_mem[i-2], ref_mem[i-3]};
        end

        reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_size = 2'd0;
        req_unsigned = 1'b0; req_addr = 32'h0; req_wr_data = 32'h0;
        repeat (2) @(negedge clk);
        checkOutput("reset_mem_reset", {31'h0, mem_reset}, 32'd1);
        checkOutput("reset_rsp_valid", {31'h0, rsp_valid}, 32'd0);
        checkOutput("reset_rsp_fault", {31'h0, rsp_fault}, 32'd0);
        checkOutput("reset_rsp_data", rsp_rd_data, 32'h0);
        checkOutput("reset_rd_en", {31'h0, mem_rd_en}, 32'd0);
        checkOutput("reset_wr_en", {28'h0, mem_wr_en}, 32'h0);
        checkOutput("reset_address", {25'h0, mem_address}, 32'h0);
        checkOutput("reset_wr_data", mem_wr_data, 32'h0);
        reset = 1'b0;
        @(negedge clk);
        checkOutput("idle_ready", {31'h0, req_ready}, 32'd1);
        checkOutput("mem_reset_low", {31'h0, mem_reset}, 32'd0);

        $display("[TB] directed vectors");
        applyStimulus(1'b1, 2'd2, 1'b0, 32'h08, 32'hDEADBEEF);
        applyStimulus(1'b1, 2'd0, 1'b0, 32'h0D, 32'h000000A5);
        checkOutput("byte_store_mask", {28'h0, obs_mask}, 32'h2);
        checkOutput("byte_store_data", obs_wdata, 32'hA5A5A5A5);
        applyStimulus(1'b0, 2'd0, 1'b0, 32'h0D, 32'h0);
        checkOutput("byte_load_signed", obs_data, 32'hFFFFFFA5);
        applyStimulus(1'b0, 2'd0, 1'b1, 32'h0D, 32'h0);
        checkOutput("byte_load_unsigned", obs_data, 32'h000000A5);
        applyStimulus(1'b1, 2'd2, 1'b0, 32'h08, 32'h80011234);
        applyStimulus(1'b0, 2'd1, 1'b0, 32'h0A, 32'h0);
        checkOutput("half_load_signed", obs_data, 32'hFFFF8001);
        applyStimulus(1'b0, 2'd1, 1'b1, 32'h0A, 32'h0);
        checkOutput("half_load_unsigned", obs_data, 32'h00008001);
        applyStimulus(1'b0, 2'd2, 1'b0, 32'h06, 32'h0);
        applyStimulus(1'b0, 2'd2, 1'b0, 32'h80, 32'h0);
        checkOutput("range_fault", {31'h0, obs_fault}, 32'd1);
        applyStimulus(1'b1, 2'd3, 1'b0, 32'h04, 32'h12345678);
        checkOutput("size_fault", {31'h0, obs_fault}, 32'd1);
        applyStimulus(1'b0, 2'd2, 1'b0, 32'h7C, 32'h0);

        $display("[TB] reset during store access");
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b1; req_size = 2'd2;
        req_unsigned = 1'b0; req_addr = 32'h10; req_wr_data = 32'h11223344;
        @(negedge clk);
        req_valid = 1'b0;
        checkOutput("rst_access_wr_en", {28'h0, mem_wr_en}, 32'hF);
        reset = 1'b1;
        #1;
        checkOutput("rst_gate_wr_en", {28'h0, mem_wr_en}, 32'h0);
        @(negedge clk);
        checkOutput("rst_after_wr_en", {28'h0, mem_wr_en}, 32'h0);
        checkOutput("rst_after_rsp", {31'h0, rsp_valid}, 32'd0);
        reset = 1'b0;
        @(negedge clk);
        checkOutput("rst_ready", {31'h0, req_ready}, 32'd1);
        checkOutput("rst_no_rsp", {31'h0, rsp_valid}, 32'd0);
        ref_word = {ref_mem[19], ref_mem[18], ref_mem[17], ref_mem[16]};
        checkOutput("rst_mem_unchanged", mem_word[4], ref_word);

        $display("[TB] random traffic");
        for (int t = 0; t < 300; t++) begin
            r_addr = ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, CAP - 1));
            applyStimulus(1'($urandom), ($urandom_range(0, 7) == 0) ? 2'd3 : 2'($urandom_range(0, 2)),
                          1'($urandom), r_addr, $urandom);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assertion_count, fail_count);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: observed timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter CAPACITY_BYTES, default 128, meaning memory size in bytes (power of two).
REQ-002 SHALL have parameter BYTES_PER_WORD, default 4, meaning memory word width in bytes; only 4 is supported.
REQ-003 SHALL derive ADDR_BITS = $clog2(CAPACITY_BYTES) as a localparam.
REQ-004 SHALL have port clk  in  1  sole clock; all logic is rising-edge.
REQ-005 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-006 SHALL have port req_valid  in  1  request present.
REQ-007 SHALL have port req_ready  out  1  request accepted when high with req_valid.
REQ-008 SHALL have port req_write  in  1  1 = store, 0 = load.
REQ-009 SHALL have port req_size  in  2  00 byte, 01 half, 10 word, 11 illegal.
REQ-010 SHALL have port req_unsigned  in  1  zero-extend (1) or sign-extend (0) loads.
REQ-011 SHALL have port req_addr  in  32  byte address.
REQ-012 SHALL have port req_wr_data  in  32  store data, right-aligned.
REQ-013 SHALL have port rsp_valid  out  1  one-cycle completion pulse.
REQ-014 SHALL have port rsp_rd_data  out  32  extended load data; 0 for stores and faults.
REQ-015 SHALL have port rsp_fault  out  1  request faulted; qualified by rsp_valid.
REQ-016 SHALL have ports mem_reset out 1, mem_address out ADDR_BITS, mem_rd_en out 1, mem_wr_data out 32, mem_wr_en out 4, mem_rd_data in 32, driving one memory port.

Function
REQ-017 SHALL implement FSM states IDLE, ACCESS, RESP; req_ready = 1 only in IDLE.
REQ-018 SHALL, on accept in IDLE, register the request; go to ACCESS if no fault, else RESP.
REQ-019 SHALL, in ACCESS only, drive mem_address = {req_addr[ADDR_BITS-1:2],2'b00} and mem_rd_en = !write; for stores, mem_wr_en = byte 0001<<addr[1:0], half 0011<<addr[1:0], word 1111.
REQ-020 SHALL, outside ACCESS, hold mem_rd_en = 0 and mem_wr_en = 0000.
REQ-021 SHALL replicate store data across lanes: byte x4, half x2, word as-is.
REQ-022 SHALL always transition ACCESS -> RESP, then RESP -> IDLE; rsp_valid = 1 exactly in RESP.
REQ-023 SHALL, in RESP for loads, select the lane from mem_rd_data by registered addr[1:0] and size, and extend it per req_unsigned.
REQ-024 SHALL flag a fault for req_size = 11 or req_addr >= CAPACITY_BYTES; no memory access occurs, rsp_rd_data = 0.
REQ-025 SHALL have latency: accept at edge N, rsp_valid during cycle N+2 (N+1 for faults); the next accept is possible one cycle after RESP.
REQ-026 SHALL NOT provide response backpressure; the consumer must sample rsp_valid.

Reset
REQ-027 SHALL, on reset, enter IDLE with rsp_valid=0, rsp_fault=0, rsp_rd_data=0, mem_rd_en=0, mem_wr_en=0000, mem_address=0, mem_wr_data=0.
REQ-028 SHALL drop an in-flight request on reset at any state, without issuing a response; a store in ACCESS during reset SHALL NOT be written.
REQ-029 SHALL drive mem_reset directly from reset.

Configuration
REQ-030 SHALL, with LSU_ALIGN_CHECK_EN defined, fault on a half at an odd address or a word with addr[1:0] != 00.
REQ-031 SHALL, without LSU_ALIGN_CHECK_EN defined, force-align misaligned accesses by clearing addr[0] (half) or addr[1:0] (word), without raising a fault.

Structure
REQ-032 SHALL place the size encoding enum, the FSM state enum, and the fault conditions in the shared package lsu_pkg.
REQ-033 SHALL implement byte-lane steering and extension in the combinational sub-module lsu_lane_align.

Verification
REQ-034 Word store at 0x08 data 0xDEADBEEF -> in ACCESS, mem_wr_en=1111, mem_address=0x08; rsp_valid=1, rsp_fault=0 two cycles after accept.
REQ-035 Byte store 0xA5 at 0x0D, then signed byte load at 0x0D -> mem_wr_en=0010, mem_wr_data=0xA5A5A5A5; load returns 0xFFFFFFA5, and 0x000000A5 when unsigned.
REQ-036 Half load at 0x0A over stored word 0x8001_1234 -> signed returns 0xFFFF8001, unsigned returns 0x00008001.
REQ-037 Word load at 0x06 -> with LSU_ALIGN_CHECK_EN: rsp_fault=1 at N+1, no mem_rd_en; without the macro: data from 0x04, rsp_fault=0.
REQ-038 Load at 0x80 (CAPACITY_BYTES=128) -> rsp_fault=1, rsp_rd_data=0, mem_rd_en never asserted.
REQ-039 Reset asserted in ACCESS of a store -> mem_wr_en=0000 after the edge, no rsp_valid, memory unchanged, req_ready=1 next cycle.
